// File: rtl/dmem_banked_rsp_if.sv
// Request/response bus between a load/store unit and dmem_banked_rsp.
//
// Signals (named from the memory's point of view):
//   req_i      request valid
//   we_i       1 = store, 0 = load
//   addr_i     byte address
//   size_i     00 byte, 01 half, 10/11 word
//   unsigned_i loads: 1 = zero-extend, 0 = sign-extend
//   wdata_i    right-aligned store data
//   gnt_o      request accepted when req_i && gnt_o
//   rvalid_o   registered response valid, one per accepted request
//   rdata_o    extended load data (0 for stores and errors)
//   err_o      response is an error, qualified by rvalid_o
//
// Modports: master drives the request, slave is the memory.
interface dmem_banked_rsp_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [1:0]            size_i;
  logic                  unsigned_i;
  logic [31:0]           wdata_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [31:0]           rdata_o;
  logic                  err_o;

  modport master (
    output req_i, we_i, addr_i, size_i, unsigned_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, size_i, unsigned_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_banked_rsp.sv
// Byte-banked RISC-V data memory for the load/store unit.
// Four byte-wide banks hold one lane each, so any byte/half/word access
// (including one that straddles a word boundary) completes in a single cycle:
// the bank just above the boundary simply uses the next word index.
// Loads are extended (LB/LH/LBU/LHU/LW) and registered into the response.
// An optional clear sweep zeroes the banks after reset before any grant.
//
// Ports:
//   clk_i  clock, all state updates on posedge
//   rst_i  asynchronous active-high reset
//   bus    dmem_banked_rsp_if.slave: req/gnt request side plus
//          rvalid/rdata/err registered response side
module dmem_banked_rsp #(
  parameter int DMEM_DEPTH       = 1024,
  parameter int DMEM_ADDR_WIDTH  = 12,
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter bit CLEAR_ON_RESET   = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  dmem_banked_rsp_if.slave bus
);

  localparam int                     IDX_W    = DMEM_ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(DMEM_DEPTH - 1);
  localparam int unsigned            MAX_BYTE = DMEM_DEPTH * 4 - 1;
  localparam logic [DMEM_ADDR_WIDTH:0] MAX_ADDR = (DMEM_ADDR_WIDTH + 1)'(MAX_BYTE);

  typedef enum logic {
    StClear,
    StReady
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         clrCnt_q, clrCnt_d;
  logic                     rvalid_q, rvalid_d;
  logic                     err_q, err_d;
  logic [31:0]              rdata_q, rdata_d;

  logic                     gnt;
  logic                     accept;
  logic [1:0]               offset;
  logic [IDX_W-1:0]         wordIdx;
  logic [2:0]               lastOff;
  logic [DMEM_ADDR_WIDTH:0] lastAddr;
  logic                     misaligned;
  logic                     rangeErr;
  logic                     accErr;
  logic [3:0]               sizeMask;
  logic [3:0]               byteEn;
  logic [31:0]              laneWData;
  logic [31:0]              laneRData;
  logic [31:0]              loadData;
  logic [31:0]              loadExt;

  assign offset  = bus.addr_i[1:0];
  assign wordIdx = bus.addr_i[DMEM_ADDR_WIDTH-1:2];
  assign accept  = bus.req_i && gnt;

  // State register: the clear counter restarts from word 0 on every reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= CLEAR_ON_RESET ? StClear : StReady;
      clrCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
    end
  end

  // Next state: one word per cycle, leave CLEAR after the last word is zeroed.
  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    if (state_q == StClear) begin
      clrCnt_d = clrCnt_q + IDX_W'(1);
      if (clrCnt_q == LAST_IDX) begin
        state_d  = StReady;
        clrCnt_d = '0;
      end
    end
  end

  // Output decode: grant only in READY, and never while reset is held.
  always_comb begin
    gnt = (state_q == StReady) && !rst_i;
  end

  // Access checks. lastAddr is one bit wider so the top byte cannot wrap to 0.
  always_comb begin
    unique case (bus.size_i)
      2'b00:   begin lastOff = 3'd0; sizeMask = 4'b0001; end
      2'b01:   begin lastOff = 3'd1; sizeMask = 4'b0011; end
      default: begin lastOff = 3'd3; sizeMask = 4'b1111; end
    endcase
    lastAddr   = {1'b0, bus.addr_i} + (DMEM_ADDR_WIDTH + 1)'(lastOff);
    rangeErr   = (lastAddr > MAX_ADDR);
    misaligned = ((bus.size_i == 2'b01) && bus.addr_i[0]) ||
                 (bus.size_i[1] && (offset != 2'b00));
    accErr     = rangeErr || (misaligned && !ALLOW_MISALIGNED);
  end

  // Lane steering: store data and enables rotate left by the byte offset,
  // read lanes rotate right by the same amount back to bit 0.
  always_comb begin
    unique case (offset)
      2'd0: begin
        laneWData = bus.wdata_i;
        byteEn    = sizeMask;
        loadData  = laneRData;
      end
      2'd1: begin
        laneWData = {bus.wdata_i[23:0], bus.wdata_i[31:24]};
        byteEn    = {sizeMask[2:0], sizeMask[3]};
        loadData  = {laneRData[7:0], laneRData[31:8]};
      end
      2'd2: begin
        laneWData = {bus.wdata_i[15:0], bus.wdata_i[31:16]};
        byteEn    = {sizeMask[1:0], sizeMask[3:2]};
        loadData  = {laneRData[15:0], laneRData[31:16]};
      end
      default: begin
        laneWData = {bus.wdata_i[7:0], bus.wdata_i[31:8]};
        byteEn    = {sizeMask[0], sizeMask[3:1]};
        loadData  = {laneRData[23:0], laneRData[31:24]};
      end
    endcase
  end

  // Sign/zero extension; unsigned_i has no effect on word loads.
  always_comb begin
    unique case (bus.size_i)
      2'b00:   loadExt = {{24{loadData[7] & ~bus.unsigned_i}}, loadData[7:0]};
      2'b01:   loadExt = {{16{loadData[15] & ~bus.unsigned_i}}, loadData[15:0]};
      default: loadExt = loadData;
    endcase
  end

  // Byte banks. Banks below the start offset belong to the next word.
  for (genvar b = 0; b < 4; b++) begin : gBank
    logic [7:0]       bank_q [DMEM_DEPTH];
    logic [IDX_W-1:0] idx;

    assign idx = wordIdx + {{(IDX_W - 1){1'b0}}, (2'(b) < offset)};

    // The clear sweep needs no arbitration: nothing is granted during it.
    always_ff @(posedge clk_i) begin
      if (state_q == StClear) begin
        bank_q[clrCnt_q] <= '0;
      end else if (accept && bus.we_i && !accErr && byteEn[b]) begin
        bank_q[idx] <= laneWData[8*b +: 8];
      end
    end

    assign laneRData[8*b +: 8] = bank_q[idx];
  end

  // Response next-state: data and error hold between responses.
  always_comb begin
    rvalid_d = accept;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (accept) begin
      err_d   = accErr;
      rdata_d = (bus.we_i || accErr) ? 32'h0 : loadExt;
    end
  end

  // Response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;

endmodule

// File: tb/tb_dmem_banked_rsp.sv
// Self-checking bench for dmem_banked_rsp.
// dutA: 16 words, misaligned allowed, clear after reset.
// dutB: 16 words, misaligned rejected, no clear.
// Expected responses come from a byte-level reference memory and are queued
// when a request is driven, then popped when the response appears.
module tb_dmem_banked_rsp;

  localparam int DEPTH  = 16;
  localparam int AW     = 6;
  localparam int NBYTES = DEPTH * 4;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        gnt;
  } obs_t;

  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;

  always #5 clk = ~clk;

  dmem_banked_rsp_if #(.ADDR_WIDTH(AW)) ifA ();
  dmem_banked_rsp_if #(.ADDR_WIDTH(AW)) ifB ();

  dmem_banked_rsp #(
    .DMEM_DEPTH(DEPTH), .DMEM_ADDR_WIDTH(AW),
    .ALLOW_MISALIGNED(1'b1), .CLEAR_ON_RESET(1'b1)
  ) dutA (
    .clk_i(clk), .rst_i(rstA), .bus(ifA.slave)
  );

  dmem_banked_rsp #(
    .DMEM_DEPTH(DEPTH), .DMEM_ADDR_WIDTH(AW),
    .ALLOW_MISALIGNED(1'b0), .CLEAR_ON_RESET(1'b0)
  ) dutB (
    .clk_i(clk), .rst_i(rstB), .bus(ifB.slave)
  );

  logic [7:0] refMem [2][NBYTES];
  exp_t       sbA[$];
  exp_t       sbB[$];
  int         nCompared = 0;
  int         nMismatch = 0;

  // Byte-level reference: d selects the instance (0 = A allows misaligned).
  function automatic exp_t predict(input int d, input logic we, input int addr,
                                   input logic [1:0] size, input logic uns,
                                   input logic [31:0] wdata);
    exp_t        r;
    int          n;
    bit          mis;
    logic [31:0] v;
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mis = ((n == 2) && (addr % 2 != 0)) || ((n == 4) && (addr % 4 != 0));
    r.data = 32'h0;
    r.err  = ((addr + n - 1) > (NBYTES - 1)) || (mis && (d != 0));
    if (!r.err) begin
      if (we) begin
        for (int i = 0; i < n; i++) refMem[d][addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[d][addr + i];
        if (n == 1)      v = {{24{v[7] & ~uns}}, v[7:0]};
        else if (n == 2) v = {{16{v[15] & ~uns}}, v[15:0]};
        r.data = v;
      end
    end
    return r;
  endfunction

  task automatic drive(input int d, input logic we, input logic [5:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    exp_t e;
    e = predict(d, we, int'(addr), size, uns, wdata);
    if (d == 0) begin
      ifA.req_i = 1'b1; ifA.we_i = we; ifA.addr_i = addr;
      ifA.size_i = size; ifA.unsigned_i = uns; ifA.wdata_i = wdata;
      sbA.push_back(e);
    end else begin
      ifB.req_i = 1'b1; ifB.we_i = we; ifB.addr_i = addr;
      ifB.size_i = size; ifB.unsigned_i = uns; ifB.wdata_i = wdata;
      sbB.push_back(e);
    end
  endtask

  task automatic idle(input int d);
    if (d == 0) begin
      ifA.req_i = 1'b0; ifA.we_i = 1'b0; ifA.addr_i = '0;
      ifA.size_i = 2'b00; ifA.unsigned_i = 1'b0; ifA.wdata_i = '0;
    end else begin
      ifB.req_i = 1'b0; ifB.we_i = 1'b0; ifB.addr_i = '0;
      ifB.size_i = 2'b00; ifB.unsigned_i = 1'b0; ifB.wdata_i = '0;
    end
  endtask

  function automatic obs_t sample(input int d);
    if (d == 0) return '{ifA.rvalid_o, ifA.rdata_o, ifA.err_o, ifA.gnt_o};
    return '{ifB.rvalid_o, ifB.rdata_o, ifB.err_o, ifB.gnt_o};
  endfunction

  function automatic int sbSize(input int d);
    return (d == 0) ? sbA.size() : sbB.size();
  endfunction

  function automatic exp_t popExp(input int d);
    if (d == 0) return sbA.pop_front();
    return sbB.pop_front();
  endfunction

  // Reset values on both instances, then clear length on A and immediate grant on B.
  task automatic test_reset();
    obs_t o;
    int   cyc;
    rstA = 1'b1; rstB = 1'b1;
    idle(0); idle(1);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NBYTES; i++) refMem[d][i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      o = sample(d);
      nCompared++;
      if (o !== '0) begin
        nMismatch++;
        $display("[TB] FAIL reset_out[%0d]: got rvalid=%b rdata=%h err=%b gnt=%b, required all 0",
                 d, o.rvalid, o.rdata, o.err, o.gnt);
      end
    end
    rstA = 1'b0; rstB = 1'b0;
    #1;
    o = sample(1);
    nCompared++;
    if (o.gnt !== 1'b1) begin
      nMismatch++;
      $display("[TB] FAIL noclear_gnt: got %b, required 1", o.gnt);
    end
    cyc = 0;
    while (ifA.gnt_o !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    nCompared++;
    if (cyc != DEPTH) begin
      nMismatch++;
      $display("[TB] FAIL clear_len: got %0d cycles without grant, required %0d", cyc, DEPTH);
    end
  endtask

  // Fill A, reset mid-clear, verify the restarted clear and an all-zero memory.
  task automatic test_clear_restart();
    obs_t o;
    exp_t e;
    int   cyc;
    for (int w = 0; w <= DEPTH; w++) begin
      if (w < DEPTH) drive(0, 1'b1, 6'(4 * w), 2'b10, 1'b0, 32'hA5A50000 | 32'(w + 1));
      else           drive(0, 1'b0, 6'h04, 2'b10, 1'b0, 32'h0);
      @(posedge clk); #1;
      o = sample(0);
      nCompared++;
      if (o.rvalid !== 1'b1) begin
        nMismatch++;
        $display("[TB] FAIL fill_rvalid[%0d]: got %b, required 1", w, o.rvalid);
      end
      e = popExp(0);
      nCompared++;
      if (o.rdata !== e.data || o.err !== e.err) begin
        nMismatch++;
        $display("[TB] FAIL fill_rsp[%0d]: got %h/%b, required %h/%b", w, o.rdata, o.err, e.data, e.err);
      end
    end
    idle(0);
    rstA = 1'b1;
    #1;
    o = sample(0);
    nCompared++;
    if (o !== '0) begin
      nMismatch++;
      $display("[TB] FAIL rereset_out: got rvalid=%b rdata=%h err=%b gnt=%b, required all 0",
               o.rvalid, o.rdata, o.err, o.gnt);
    end
    @(posedge clk); #1;
    rstA = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstA = 1'b1;
    @(posedge clk); #1;
    rstA = 1'b0;
    for (int i = 0; i < NBYTES; i++) refMem[0][i] = 8'h00;
    cyc = 0;
    while (ifA.gnt_o !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    nCompared++;
    if (cyc != DEPTH) begin
      nMismatch++;
      $display("[TB] FAIL restart_len: got %0d cycles without grant, required %0d", cyc, DEPTH);
    end
    for (int w = 0; w < DEPTH; w++) begin
      drive(0, 1'b0, 6'(4 * w), 2'b10, 1'b0, 32'h0);
      @(posedge clk); #1;
      o = sample(0);
      e = popExp(0);
      nCompared++;
      if (o.rvalid !== 1'b1 || o.rdata !== 32'h0 || o.err !== 1'b0 || e.data !== 32'h0) begin
        nMismatch++;
        $display("[TB] FAIL clear_word[%0d]: got rvalid=%b rdata=%h err=%b, required 1/00000000/0",
                 w, o.rvalid, o.rdata, o.err);
      end
    end
    idle(0);
  endtask

  task automatic test_aligned();
    vec_t tbl [5];
    obs_t o;
    exp_t e;
    tbl[0] = '{1'b1, 6'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1] = '{1'b0, 6'h10, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 6'h13, 2'b00, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0};
    tbl[3] = '{1'b0, 6'h13, 2'b00, 1'b1, 32'h0,        32'h000000DE, 1'b0};
    tbl[4] = '{1'b0, 6'h10, 2'b01, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata);
      @(posedge clk); #1;
      o = sample(0);
      e = popExp(0);
      nCompared++;
      if (o.rvalid !== 1'b1) begin
        nMismatch++;
        $display("[TB] FAIL aligned_rvalid[%0d]: got %b, required 1", i, o.rvalid);
      end
      nCompared++;
      if (o.rdata !== tbl[i].expData || o.err !== tbl[i].expErr || e.data !== tbl[i].expData) begin
        nMismatch++;
        $display("[TB] FAIL aligned_rsp[%0d]: got %h/%b, required %h/%b", i, o.rdata, o.err,
                 tbl[i].expData, tbl[i].expErr);
      end
    end
    idle(0);
    @(posedge clk); #1;
    o = sample(0);
    nCompared++;
    if (o.rvalid !== 1'b0) begin
      nMismatch++;
      $display("[TB] FAIL aligned_rvalid_drop: got %b, required 0", o.rvalid);
    end
  endtask

  task automatic test_misaligned();
    vec_t tbl [8];
    obs_t o;
    exp_t e;
    tbl[0] = '{1'b1, 6'h0E, 2'b10, 1'b0, 32'h11223344, 32'h00000000, 1'b0};
    tbl[1] = '{1'b0, 6'h0E, 2'b10, 1'b0, 32'h0,        32'h11223344, 1'b0};
    tbl[2] = '{1'b0, 6'h0F, 2'b01, 1'b1, 32'h0,        32'h00002233, 1'b0};
    tbl[3] = '{1'b0, 6'h0E, 2'b00, 1'b0, 32'h0,        32'h00000044, 1'b0};
    tbl[4] = '{1'b0, 6'h10, 2'b10, 1'b0, 32'h0,        32'hDEAD1122, 1'b0};
    tbl[5] = '{1'b0, 6'h11, 2'b01, 1'b0, 32'h0,        32'hFFFFAD11, 1'b0};
    tbl[6] = '{1'b0, 6'h0D, 2'b10, 1'b0, 32'h0,        32'h22334400, 1'b0};
    tbl[7] = '{1'b0, 6'h0F, 2'b11, 1'b0, 32'h0,        32'hAD112233, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata);
      @(posedge clk); #1;
      o = sample(0);
      e = popExp(0);
      nCompared++;
      if (o.rvalid !== 1'b1 || o.rdata !== e.data || o.err !== e.err) begin
        nMismatch++;
        $display("[TB] FAIL misaligned_model[%0d]: got %b/%h/%b, required 1/%h/%b", i,
                 o.rvalid, o.rdata, o.err, e.data, e.err);
      end
      nCompared++;
      if (o.rdata !== tbl[i].expData || o.err !== tbl[i].expErr) begin
        nMismatch++;
        $display("[TB] FAIL misaligned_const[%0d]: got %h/%b, required %h/%b", i, o.rdata, o.err,
                 tbl[i].expData, tbl[i].expErr);
      end
    end
    idle(0);
  endtask

  task automatic test_misaligned_err();
    vec_t tbl [8];
    obs_t o;
    exp_t e;
    tbl[0] = '{1'b1, 6'h0C, 2'b10, 1'b0, 32'h01020304, 32'h00000000, 1'b0};
    tbl[1] = '{1'b1, 6'h10, 2'b10, 1'b0, 32'h05060708, 32'h00000000, 1'b0};
    tbl[2] = '{1'b1, 6'h0E, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[3] = '{1'b0, 6'h0C, 2'b10, 1'b0, 32'h0,        32'h01020304, 1'b0};
    tbl[4] = '{1'b0, 6'h10, 2'b10, 1'b0, 32'h0,        32'h05060708, 1'b0};
    tbl[5] = '{1'b0, 6'h01, 2'b01, 1'b0, 32'h0,        32'h00000000, 1'b1};
    tbl[6] = '{1'b0, 6'h0E, 2'b01, 1'b1, 32'h0,        32'h00000102, 1'b0};
    tbl[7] = '{1'b0, 6'h0E, 2'b10, 1'b0, 32'h0,        32'h00000000, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(1, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata);
      @(posedge clk); #1;
      o = sample(1);
      e = popExp(1);
      nCompared++;
      if (o.rvalid !== 1'b1 || o.rdata !== e.data || o.err !== e.err) begin
        nMismatch++;
        $display("[TB] FAIL noalign_model[%0d]: got %b/%h/%b, required 1/%h/%b", i,
                 o.rvalid, o.rdata, o.err, e.data, e.err);
      end
      nCompared++;
      if (o.rdata !== tbl[i].expData || o.err !== tbl[i].expErr) begin
        nMismatch++;
        $display("[TB] FAIL noalign_const[%0d]: got %h/%b, required %h/%b", i, o.rdata, o.err,
                 tbl[i].expData, tbl[i].expErr);
      end
    end
    idle(1);
  endtask

  task automatic test_range();
    vec_t tbl [8];
    obs_t o;
    exp_t e;
    tbl[0] = '{1'b1, 6'h3C, 2'b10, 1'b0, 32'hCAFEF00D, 32'h00000000, 1'b0};
    tbl[1] = '{1'b0, 6'h3E, 2'b10, 1'b0, 32'h0,        32'h00000000, 1'b1};
    tbl[2] = '{1'b0, 6'h3F, 2'b00, 1'b0, 32'h0,        32'hFFFFFFCA, 1'b0};
    tbl[3] = '{1'b1, 6'h3D, 2'b10, 1'b0, 32'h12345678, 32'h00000000, 1'b1};
    tbl[4] = '{1'b0, 6'h00, 2'b10, 1'b0, 32'h0,        32'h00000000, 1'b0};
    tbl[5] = '{1'b0, 6'h3E, 2'b01, 1'b0, 32'h0,        32'hFFFFCAFE, 1'b0};
    tbl[6] = '{1'b0, 6'h3F, 2'b01, 1'b0, 32'h0,        32'h00000000, 1'b1};
    tbl[7] = '{1'b0, 6'h3C, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata);
      @(posedge clk); #1;
      o = sample(0);
      e = popExp(0);
      nCompared++;
      if (o.rvalid !== 1'b1 || o.rdata !== e.data || o.err !== e.err) begin
        nMismatch++;
        $display("[TB] FAIL range_model[%0d]: got %b/%h/%b, required 1/%h/%b", i,
                 o.rvalid, o.rdata, o.err, e.data, e.err);
      end
      nCompared++;
      if (o.rdata !== tbl[i].expData || o.err !== tbl[i].expErr) begin
        nMismatch++;
        $display("[TB] FAIL range_const[%0d]: got %h/%b, required %h/%b", i, o.rdata, o.err,
                 tbl[i].expData, tbl[i].expErr);
      end
    end
    idle(0);
  endtask

  // Eight requests with req held high; each LW reads the SW of the cycle before.
  task automatic test_back_to_back();
    logic [31:0] sData [4];
    obs_t        o;
    exp_t        e;
    int          pulses;
    pulses = 0;
    for (int k = 0; k < 4; k++) sData[k] = $urandom;
    for (int i = 0; i < 8; i++) begin
      drive(0, (i % 2 == 0), 6'(32 + 4 * (i / 2)), 2'b10, 1'b0, sData[i / 2]);
      @(posedge clk); #1;
      o = sample(0);
      if (o.rvalid === 1'b1) pulses++;
      if (sbSize(0) != 0) begin
        e = popExp(0);
        nCompared++;
        if (o.rvalid !== 1'b1 || o.rdata !== e.data || o.err !== e.err) begin
          nMismatch++;
          $display("[TB] FAIL stream_model[%0d]: got %b/%h/%b, required 1/%h/%b", i,
                   o.rvalid, o.rdata, o.err, e.data, e.err);
        end
      end
      if (i % 2 == 1) begin
        nCompared++;
        if (o.rdata !== sData[i / 2]) begin
          nMismatch++;
          $display("[TB] FAIL stream_load[%0d]: got %h, required %h", i, o.rdata, sData[i / 2]);
        end
      end
    end
    idle(0);
    @(posedge clk); #1;
    o = sample(0);
    nCompared++;
    if (pulses != 8 || o.rvalid !== 1'b0) begin
      nMismatch++;
      $display("[TB] FAIL stream_pulses: got %0d pulses then rvalid=%b, required 8 then 0",
               pulses, o.rvalid);
    end
  endtask

  initial begin
    $display("[TB] starting dmem_banked_rsp bench");
    test_reset();
    test_clear_restart();
    test_aligned();
    test_misaligned();
    test_misaligned_err();
    test_range();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
